// File: rtl/mawg_cfg_pkg.sv
// Shared config-path definitions: frame geometry, command codes and the
// serializer state encoding used by the UART frame transmitter.
package mawg_cfg_pkg;

  localparam int FRAME_BYTES = 5;
  localparam int FRAME_W     = FRAME_BYTES * 8;

  localparam logic [7:0] CMD_OUT         = 8'd0;
  localparam logic [7:0] CMD_WAVE        = 8'd1;
  localparam logic [7:0] CMD_CTRL        = 8'd2;
  localparam logic [7:0] CMD_CHIRP_REV   = 8'd3;
  localparam logic [7:0] CMD_CHIRP_DELAY = 8'd4;
  localparam logic [7:0] CMD_CHIRP_MIN   = 8'd5;
  localparam logic [7:0] CMD_CHIRP_MAX   = 8'd6;
  localparam logic [7:0] CMD_CHIRP_DIV   = 8'd7;
  localparam logic [7:0] CMD_CHIRP_INC   = 8'd8;
  localparam logic [7:0] CMD_PULSE_DUTY  = 8'd9;
  localparam logic [7:0] CMD_FM_CTR      = 8'd10;
  localparam logic [7:0] CMD_FM_DEV      = 8'd11;
  localparam logic [7:0] CMD_FM_DEMOD    = 8'd12;
  localparam logic [7:0] CMD_CLEAR_ALL   = 8'd15;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_STOP  = 3'd3,
    TX_GAP   = 3'd4
  } tx_state_e;

  typedef enum logic [0:0] {
    FR_IDLE = 1'b0,
    FR_BUSY = 1'b1
  } frame_state_e;

  // Rotation keeps every latched bit live; the byte after the current one sits in [31:24].
  function automatic logic [FRAME_W-1:0] frame_rotate(input logic [FRAME_W-1:0] frame);
    return {frame[FRAME_W-9:0], frame[FRAME_W-1:FRAME_W-8]};
  endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// Host-side request/completion handshake of the UART frame transmitter.
interface uart_frame_tx_if;

  logic        start;
  logic [7:0]  cmd;
  logic [31:0] payload;
  logic        ready;
  logic        done;

  modport master (
    output start,
    output cmd,
    output payload,
    input  ready,
    input  done
  );

  modport slave (
    input  start,
    input  cmd,
    input  payload,
    output ready,
    output done
  );

endinterface

// File: rtl/uart_tx_byte.sv
// Serializes one byte as start, 8 data bits LSB first, stop and GAP_BITS idle
// periods; byte_done marks the last cycle so the next byte can follow seamlessly.
module uart_tx_byte
  import mawg_cfg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int GAP_BITS     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_start,
  input  logic [7:0] byte_data,
  output logic       byte_done,
  output logic       tx
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 32'sd1);
  localparam logic [3:0]  GAP_LAST  = (GAP_BITS > 32'sd0) ? 4'(GAP_BITS - 32'sd1) : 4'd0;

  tx_state_e   state_r, state_s;
  logic [15:0] baud_r, baud_s;
  logic [2:0]  bit_r, bit_s;
  logic [3:0]  gap_r, gap_s;
  logic [7:0]  data_r, data_s;
  logic        tx_r, tx_s;
  logic        baud_end_s;
  logic        byte_end_s;

  assign baud_end_s = (baud_r == BAUD_LAST);
  assign byte_done  = byte_end_s;
  assign tx         = tx_r;

  // Next-state, counter and line-level decode for the byte serializer.
  always_comb begin
    state_s    = state_r;
    baud_s     = 16'd0;
    bit_s      = bit_r;
    gap_s      = gap_r;
    data_s     = data_r;
    tx_s       = tx_r;
    byte_end_s = 1'b0;

    if ((state_r != TX_IDLE) && !baud_end_s) begin
      baud_s = baud_r + 16'd1;
    end else begin
      baud_s = 16'd0;
    end

    case (state_r)
      TX_IDLE: begin
        tx_s = 1'b1;
      end
      TX_START: begin
        if (baud_end_s) begin
          state_s = TX_DATA;
          bit_s   = 3'd0;
          tx_s    = data_r[0];
        end else begin
          tx_s = 1'b0;
        end
      end
      TX_DATA: begin
        if (baud_end_s) begin
          if (bit_r == 3'd7) begin
            state_s = TX_STOP;
            tx_s    = 1'b1;
          end else begin
            bit_s  = bit_r + 3'd1;
            data_s = {1'b0, data_r[7:1]};
            tx_s   = data_r[1];
          end
        end else begin
          tx_s = tx_r;
        end
      end
      TX_STOP: begin
        if (baud_end_s) begin
          if (GAP_BITS == 32'sd0) begin
            byte_end_s = 1'b1;
          end else begin
            state_s = TX_GAP;
            gap_s   = 4'd0;
          end
        end else begin
          tx_s = 1'b1;
        end
      end
      TX_GAP: begin
        if (baud_end_s) begin
          if (gap_r == GAP_LAST) begin
            byte_end_s = 1'b1;
          end else begin
            gap_s = gap_r + 4'd1;
          end
        end else begin
          tx_s = 1'b1;
        end
      end
      default: begin
        state_s = TX_IDLE;
        tx_s    = 1'b1;
      end
    endcase

    // A new byte may load from idle or directly on the last cycle of the previous one.
    if (byte_start && ((state_r == TX_IDLE) || byte_end_s)) begin
      state_s = TX_START;
      baud_s  = 16'd0;
      bit_s   = 3'd0;
      gap_s   = 4'd0;
      data_s  = byte_data;
      tx_s    = 1'b0;
    end else if (byte_end_s) begin
      state_s = TX_IDLE;
      baud_s  = 16'd0;
      tx_s    = 1'b1;
    end else begin
      state_s = state_s;
    end
  end

  // Serializer state, counters and registered line output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= TX_IDLE;
      baud_r  <= 16'd0;
      bit_r   <= 3'd0;
      gap_r   <= 4'd0;
      data_r  <= 8'd0;
      tx_r    <= 1'b1;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      gap_r   <= gap_s;
      data_r  <= data_s;
      tx_r    <= tx_s;
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Sends a 5-byte config frame (cmd, then payload MSB first) over UART and
// reports frame-level ready/done to the host.
module uart_frame_tx
  import mawg_cfg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int GAP_BITS     = 1
) (
  input  logic           clk,
  input  logic           rst,
  uart_frame_tx_if.slave bus,
  output logic           TX
);

  localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 32'sd1);

  frame_state_e       state_r, state_s;
  logic [FRAME_W-1:0] shift_r, shift_s;
  logic [2:0]         idx_r, idx_s;
  logic               ready_r, ready_s;
  logic               done_r, done_s;
  logic               byte_start_s;
  logic [7:0]         byte_data_s;
  logic               byte_done_s;

  assign bus.ready = ready_r;
  assign bus.done  = done_r;

  // Frame sequencing: accept, feed bytes in order, flag completion after the last one.
  always_comb begin
    state_s      = state_r;
    shift_s      = shift_r;
    idx_s        = idx_r;
    byte_start_s = 1'b0;
    byte_data_s  = 8'h00;
    done_s       = 1'b0;

    case (state_r)
      FR_IDLE: begin
        if (bus.start && ready_r) begin
          state_s      = FR_BUSY;
          shift_s      = {bus.cmd, bus.payload};
          idx_s        = 3'd0;
          byte_start_s = 1'b1;
          byte_data_s  = bus.cmd;
        end else begin
          idx_s = 3'd0;
        end
      end
      FR_BUSY: begin
        if (byte_done_s) begin
          if (idx_r == LAST_BYTE) begin
            state_s = FR_IDLE;
            done_s  = 1'b1;
          end else begin
            idx_s        = idx_r + 3'd1;
            byte_start_s = 1'b1;
            byte_data_s  = shift_r[31:24];
            shift_s      = frame_rotate(shift_r);
          end
        end else begin
          shift_s = shift_r;
        end
      end
      default: begin
        state_s = FR_IDLE;
      end
    endcase

    ready_s = (state_s == FR_IDLE);
  end

  // Frame state, latched data and registered host outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= FR_IDLE;
      shift_r <= {FRAME_W{1'b0}};
      idx_r   <= 3'd0;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
      idx_r   <= idx_s;
      ready_r <= ready_s;
      done_r  <= done_s;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .GAP_BITS     (GAP_BITS)
  ) u_byte (
    .clk        (clk),
    .rst        (rst),
    .byte_start (byte_start_s),
    .byte_data  (byte_data_s),
    .byte_done  (byte_done_s),
    .tx         (TX)
  );

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scenario bench for uart_frame_tx: two instances (4 clk/bit with one gap bit,
// 2 clk/bit with no gap), a mid-bit UART sampler per line and a byte scoreboard.
module tb_uart_frame_tx;
  import mawg_cfg_pkg::*;

  localparam int CPB_A = 4;
  localparam int GAP_A = 1;
  localparam int CPB_B = 2;
  localparam int GAP_B = 0;
  localparam int N_A   = 5 * (10 + GAP_A) * CPB_A;   // 220
  localparam int N_B   = 5 * (10 + GAP_B) * CPB_B;   // 100

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx_a, tx_b;

  uart_frame_tx_if ifa ();
  uart_frame_tx_if ifb ();

  uart_frame_tx #(.CLKS_PER_BIT(CPB_A), .GAP_BITS(GAP_A)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave), .TX(tx_a));
  uart_frame_tx #(.CLKS_PER_BIT(CPB_B), .GAP_BITS(GAP_B)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave), .TX(tx_b));

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Each entry is {stop, data[7:0], start} as seen on the line.
  logic [9:0] exp_a[$], rx_a[$], exp_b[$], rx_b[$];
  logic [31:0] cfg_regs [0:15];

  // Line sampler for instance A: mid-bit samples of 10 bits after a falling edge.
  initial begin : mon_a
    int cnt; bit busy; logic [9:0] bits;
    busy = 1'b0; cnt = 0; bits = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin busy = 1'b0; cnt = 0; end
      else if (!busy) begin
        if (tx_a === 1'b0) begin busy = 1'b1; cnt = 0; end
      end else cnt++;
      if (rst && busy && (cnt % CPB_A) == (CPB_A / 2)) begin
        bits[cnt / CPB_A] = tx_a;
        if (cnt / CPB_A == 9) begin rx_a.push_back(bits); busy = 1'b0; end
      end
    end
  end

  initial begin : mon_b
    int cnt; bit busy; logic [9:0] bits;
    busy = 1'b0; cnt = 0; bits = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin busy = 1'b0; cnt = 0; end
      else if (!busy) begin
        if (tx_b === 1'b0) begin busy = 1'b1; cnt = 0; end
      end else cnt++;
      if (rst && busy && (cnt % CPB_B) == (CPB_B / 2)) begin
        bits[cnt / CPB_B] = tx_b;
        if (cnt / CPB_B == 9) begin rx_b.push_back(bits); busy = 1'b0; end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic push_frame(input bit to_b, input logic [7:0] c, input logic [31:0] p);
    if (to_b) exp_b.push_back({1'b1, c, 1'b0}); else exp_a.push_back({1'b1, c, 1'b0});
    for (int i = 3; i >= 0; i--) begin
      if (to_b) exp_b.push_back({1'b1, p[i*8 +: 8], 1'b0});
      else      exp_a.push_back({1'b1, p[i*8 +: 8], 1'b0});
    end
  endtask

  // Called in a cycle where ready=1; returns #1 into cycle 1 of the frame.
  task automatic send_a(input logic [7:0] c, input logic [31:0] p);
    push_frame(1'b0, c, p);
    ifa.start = 1'b1; ifa.cmd = c; ifa.payload = p;
    @(posedge clk); #1;
    ifa.start = 1'b0; ifa.cmd = 8'($urandom); ifa.payload = $urandom;
  endtask

  task automatic send_b(input logic [7:0] c, input logic [31:0] p);
    push_frame(1'b1, c, p);
    ifb.start = 1'b1; ifb.cmd = c; ifb.payload = p;
    @(posedge clk); #1;
    ifb.start = 1'b0; ifb.cmd = 8'($urandom); ifb.payload = $urandom;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({tx_a, ifa.ready, ifa.done, tx_b, ifb.ready, ifb.done} !== 6'b110110) begin
      tests_failed++;
      $display("FAIL reset_state: got %b expected 110110", {tx_a, ifa.ready, ifa.done, tx_b, ifb.ready, ifb.done});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({tx_a, ifa.ready, ifa.done} !== 3'b110) begin
      tests_failed++;
      $display("FAIL reset_release: got %b expected 110", {tx_a, ifa.ready, ifa.done});
    end
  endtask

  task automatic test_basic_frame;
    logic tx_h [0:230];
    logic [0:10] seq;
    logic [43:0] obs_v, exp_v;
    logic [9:0] e, r;
    int d_cnt, d_at;
    d_cnt = 0; d_at = 0;
    seq = 11'b00100000011;
    send_a(8'h02, 32'h1234_5678);
    for (int c = 1; c <= 230; c++) begin
      @(negedge clk);
      tx_h[c] = tx_a;
      if (c == N_A + 1) begin
        tests_run++;
        if ({ifa.ready, tx_a} !== 2'b11) begin
          tests_failed++;
          $display("FAIL basic_end_state: got ready/tx %b expected 11", {ifa.ready, tx_a});
        end
      end
      if (ifa.done === 1'b1) begin d_cnt++; d_at = c; end
      @(posedge clk); #1;
    end
    tests_run++;
    if (d_cnt !== 1 || d_at !== N_A + 1) begin
      tests_failed++;
      $display("FAIL basic_done: got %0d pulses last at %0d expected 1 at %0d", d_cnt, d_at, N_A + 1);
    end
    for (int c = 1; c <= 44; c++) begin
      obs_v[c-1] = tx_h[c];
      exp_v[c-1] = seq[(c-1) / CPB_A];
    end
    tests_run++;
    if (obs_v !== exp_v) begin
      tests_failed++;
      $display("FAIL basic_bits: got %b expected %b", obs_v, exp_v);
    end
    tests_run++;
    if (rx_a.size() !== exp_a.size()) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d bytes expected %0d", rx_a.size(), exp_a.size());
    end
    while (exp_a.size() > 0 && rx_a.size() > 0) begin
      e = exp_a.pop_front(); r = rx_a.pop_front();
      tests_run++;
      if (r !== e) begin tests_failed++; $display("FAIL basic_byte: got %h expected %h", r, e); end
    end
    exp_a.delete(); rx_a.delete();
  endtask

  task automatic test_back_to_back;
    int d_cnt, d1, d2, low;
    logic tx222;
    logic [9:0] e, r;
    d_cnt = 0; d1 = 0; d2 = 0; low = 0; tx222 = 1'bx;
    push_frame(1'b0, 8'h08, 32'h0000_1000);
    push_frame(1'b0, 8'h09, 32'h8000_0001);
    ifa.start = 1'b1; ifa.cmd = 8'h08; ifa.payload = 32'h0000_1000;
    @(posedge clk); #1;
    ifa.cmd = 8'h09; ifa.payload = 32'h8000_0001;
    for (int c = 1; c <= 450; c++) begin
      @(negedge clk);
      if (ifa.done === 1'b1) begin d_cnt++; if (d_cnt == 1) d1 = c; else d2 = c; end
      if (c <= 2 * N_A + 1 && ifa.ready === 1'b0) low++;
      if (c == N_A + 2) tx222 = tx_a;
      @(posedge clk); #1;
      if (c == N_A + 1) ifa.start = 1'b0;
    end
    tests_run++;
    if (d_cnt !== 2 || d1 !== 221 || d2 !== 442) begin
      tests_failed++;
      $display("FAIL b2b_done: got %0d pulses at %0d,%0d expected 2 at 221,442", d_cnt, d1, d2);
    end
    tests_run++;
    if (tx222 !== 1'b0) begin tests_failed++; $display("FAIL b2b_start_bit: got %b expected 0", tx222); end
    tests_run++;
    if (low !== 2 * N_A) begin tests_failed++; $display("FAIL b2b_ready_low: got %0d expected %0d", low, 2 * N_A); end
    tests_run++;
    if (rx_a.size() !== exp_a.size()) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d bytes expected %0d", rx_a.size(), exp_a.size());
    end
    while (exp_a.size() > 0 && rx_a.size() > 0) begin
      e = exp_a.pop_front(); r = rx_a.pop_front();
      tests_run++;
      if (r !== e) begin tests_failed++; $display("FAIL b2b_byte: got %h expected %h", r, e); end
    end
    exp_a.delete(); rx_a.delete();
  endtask

  task automatic test_ignore_busy;
    int d_cnt, d_at, bad;
    logic [9:0] e, r;
    d_cnt = 0; d_at = 0; bad = 0;
    send_a(8'h05, 32'hA5A5_0F0F);
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (ifa.done === 1'b1) begin d_cnt++; d_at = c; end
      if (c >= N_A + 2 && (tx_a !== 1'b1 || ifa.ready !== 1'b1)) bad++;
      @(posedge clk); #1;
      if (c == 49) begin ifa.start = 1'b1; ifa.cmd = CMD_CLEAR_ALL; ifa.payload = 32'hFFFF_FFFF; end
      else if (c == 50) ifa.start = 1'b0;
    end
    tests_run++;
    if (d_cnt !== 1 || d_at !== N_A + 1) begin
      tests_failed++;
      $display("FAIL busy_done: got %0d pulses last at %0d expected 1 at %0d", d_cnt, d_at, N_A + 1);
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL busy_idle_after: got %0d non-idle cycles expected 0", bad); end
    tests_run++;
    if (rx_a.size() !== exp_a.size()) begin
      tests_failed++;
      $display("FAIL busy_count: got %0d bytes expected %0d", rx_a.size(), exp_a.size());
    end
    while (exp_a.size() > 0 && rx_a.size() > 0) begin
      e = exp_a.pop_front(); r = rx_a.pop_front();
      tests_run++;
      if (r !== e) begin tests_failed++; $display("FAIL busy_byte: got %h expected %h", r, e); end
    end
    exp_a.delete(); rx_a.delete();
  endtask

  task automatic test_reset_mid_frame;
    int d_cnt, d_at;
    logic tx1;
    logic [9:0] e, r;
    d_cnt = 0; d_at = 0; tx1 = 1'bx;
    send_a(8'h0C, 32'hCAFE_F00D);
    repeat (99) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({tx_a, ifa.ready, ifa.done} !== 3'b110) begin
      tests_failed++;
      $display("FAIL midreset_async: got %b expected 110", {tx_a, ifa.ready, ifa.done});
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_a.delete(); rx_a.delete();
    @(posedge clk); #1;
    send_a(8'h01, 32'h0000_0003);
    for (int c = 1; c <= 225; c++) begin
      @(negedge clk);
      if (c == 1) tx1 = tx_a;
      if (ifa.done === 1'b1) begin d_cnt++; d_at = c; end
      @(posedge clk); #1;
    end
    tests_run++;
    if (tx1 !== 1'b0) begin tests_failed++; $display("FAIL midreset_start_bit: got %b expected 0", tx1); end
    tests_run++;
    if (d_cnt !== 1 || d_at !== N_A + 1) begin
      tests_failed++;
      $display("FAIL midreset_done: got %0d pulses last at %0d expected 1 at %0d", d_cnt, d_at, N_A + 1);
    end
    tests_run++;
    if (rx_a.size() !== exp_a.size()) begin
      tests_failed++;
      $display("FAIL midreset_count: got %0d bytes expected %0d", rx_a.size(), exp_a.size());
    end
    while (exp_a.size() > 0 && rx_a.size() > 0) begin
      e = exp_a.pop_front(); r = rx_a.pop_front();
      tests_run++;
      if (r !== e) begin tests_failed++; $display("FAIL midreset_byte: got %h expected %h", r, e); end
    end
    exp_a.delete(); rx_a.delete();
  endtask

  task automatic test_gap_zero;
    logic tx_h [0:110];
    int d_cnt, d_at;
    logic [9:0] e, r;
    d_cnt = 0; d_at = 0;
    send_b(8'h3C, 32'h0102_0304);
    for (int c = 1; c <= 110; c++) begin
      @(negedge clk);
      tx_h[c] = tx_b;
      if (c == N_B + 1) begin
        tests_run++;
        if ({ifb.ready, tx_b} !== 2'b11) begin
          tests_failed++;
          $display("FAIL gap0_end_state: got ready/tx %b expected 11", {ifb.ready, tx_b});
        end
      end
      if (ifb.done === 1'b1) begin d_cnt++; d_at = c; end
      @(posedge clk); #1;
    end
    tests_run++;
    if (d_cnt !== 1 || d_at !== N_B + 1) begin
      tests_failed++;
      $display("FAIL gap0_done: got %0d pulses last at %0d expected 1 at %0d", d_cnt, d_at, N_B + 1);
    end
    tests_run++;
    if ({tx_h[20], tx_h[21]} !== 2'b10) begin
      tests_failed++;
      $display("FAIL gap0_stop_to_start: got %b expected 10", {tx_h[20], tx_h[21]});
    end
    tests_run++;
    if (rx_b.size() !== exp_b.size()) begin
      tests_failed++;
      $display("FAIL gap0_count: got %0d bytes expected %0d", rx_b.size(), exp_b.size());
    end
    while (exp_b.size() > 0 && rx_b.size() > 0) begin
      e = exp_b.pop_front(); r = rx_b.pop_front();
      tests_run++;
      if (r !== e) begin tests_failed++; $display("FAIL gap0_byte: got %h expected %h", r, e); end
    end
    exp_b.delete(); rx_b.delete();
  endtask

  // Host-side config receiver model fed from instance A's line.
  task automatic test_loopback;
    logic [7:0]  cmds [3];
    logic [31:0] vals [3];
    logic [9:0]  f [5];
    logic [9:0]  e;
    logic [31:0] acc;
    logic [7:0]  rc;
    cmds[0] = CMD_CTRL;      vals[0] = 32'hDEAD_BEEF;
    cmds[1] = CMD_FM_CTR;    vals[1] = 32'h1234_0000;
    cmds[2] = CMD_CLEAR_ALL; vals[2] = 32'h0000_0000;
    for (int i = 0; i < 16; i++) cfg_regs[i] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      send_a(cmds[i], vals[i]);
      repeat (N_A + 4) @(posedge clk);
      #1;
      tests_run++;
      if (rx_a.size() !== 5) begin
        tests_failed++;
        $display("FAIL loop_count: got %0d bytes expected 5", rx_a.size());
      end
      if (rx_a.size() >= 5) begin
        for (int k = 0; k < 5; k++) begin
          f[k] = rx_a.pop_front();
          e = exp_a.pop_front();
          tests_run++;
          if (f[k] !== e) begin tests_failed++; $display("FAIL loop_byte: got %h expected %h", f[k], e); end
        end
        rc = f[0][8:1];
        if (rc == CMD_CLEAR_ALL) begin
          for (int j = 0; j < 16; j++) cfg_regs[j] = 32'h0;
        end else if (rc[7:4] == 4'h0) begin
          cfg_regs[rc[3:0]] = {f[1][8:1], f[2][8:1], f[3][8:1], f[4][8:1]};
        end
      end
      if (i == 1) begin
        tests_run++;
        if (cfg_regs[2] !== 32'hDEAD_BEEF) begin
          tests_failed++;
          $display("FAIL loop_ctrl_reg: got %h expected deadbeef", cfg_regs[2]);
        end
      end else if (i == 2) begin
        acc = 32'h0;
        for (int j = 0; j < 16; j++) acc = acc | cfg_regs[j];
        tests_run++;
        if (acc !== 32'h0) begin tests_failed++; $display("FAIL loop_clear_all: got OR %h expected 0", acc); end
      end
      exp_a.delete(); rx_a.delete();
    end
  endtask

  initial begin
    ifa.start = 1'b0; ifa.cmd = 8'h00; ifa.payload = 32'h0;
    ifb.start = 1'b0; ifb.cmd = 8'h00; ifb.payload = 32'h0;
    test_reset;
    test_basic_frame;
    test_back_to_back;
    test_ignore_busy;
    test_reset_mid_frame;
    test_gap_zero;
    test_loopback;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
